// File: rtl/sequencer_recorder.sv
// Live step recorder: captures one keyboard note per beat into a STEPS-slot
// pattern memory and plays it back as a note code.
module sequencer_recorder #(
    parameter int STEPS  = 16,
    parameter int NOTE_W = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     beat_pulse,
    input  logic [NOTE_W-1:0]        note_in,
    input  logic                     record_btn,
    input  logic                     play_btn,
    input  logic                     clear_btn,
    output logic [NOTE_W-1:0]        note_out,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     armed,
    output logic                     recording,
    output logic                     playing,
    output logic                     pattern_valid
);

    localparam int SW = $clog2(STEPS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RECORD = 2'd2,
        S_PLAY   = 2'd3
    } state_t;

    state_t              r_state;
    logic [SW-1:0]       r_step;
    logic [NOTE_W-1:0]   r_latch;
    logic                r_valid;
    logic [NOTE_W-1:0]   r_mem [STEPS];

    state_t              w_state_nxt;
    logic [SW-1:0]       w_step_nxt;
    logic [NOTE_W-1:0]   w_latch_nxt;
    logic                w_valid_nxt;
    logic                w_wr_en;
    logic [NOTE_W-1:0]   w_wr_data;
    logic                w_clear;
    logic                w_last_step;

    assign w_last_step = (r_step == SW'(STEPS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_latch_nxt = r_latch;
        w_valid_nxt = r_valid;
        w_wr_en     = 1'b0;
        w_wr_data   = '0;
        w_clear     = 1'b0;

        if (clear_btn) begin
            w_state_nxt = S_IDLE;
            w_step_nxt  = '0;
            w_latch_nxt = '0;
            w_valid_nxt = 1'b0;
            w_clear     = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_step_nxt = '0;
                    if (record_btn) begin
                        w_state_nxt = S_ARMED;
                    end else if (play_btn && r_valid) begin
                        w_state_nxt = S_PLAY;
                    end
                end
                S_ARMED: begin
                    w_step_nxt = '0;
                    if (record_btn) begin
                        w_state_nxt = S_IDLE;
                    end else if (beat_pulse) begin
                        w_state_nxt = S_RECORD;
                        w_latch_nxt = '0;
                    end
                end
                S_RECORD: begin
                    if (record_btn) begin
                        // Abort: the step in progress is discarded, earlier slots stay
                        w_state_nxt = S_IDLE;
                        w_step_nxt  = '0;
                        w_latch_nxt = '0;
                    end else if (beat_pulse) begin
                        w_wr_en     = 1'b1;
                        w_wr_data   = (r_latch != '0) ? r_latch : note_in;
                        w_latch_nxt = '0;
                        if (w_last_step) begin
                            w_state_nxt = S_IDLE;
                            w_step_nxt  = '0;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_step_nxt = r_step + SW'(1);
                        end
                    end else if (r_latch == '0 && note_in != '0) begin
                        w_latch_nxt = note_in;
                    end
                end
                S_PLAY: begin
                    if (record_btn) begin
                        w_state_nxt = S_ARMED;
                        w_step_nxt  = '0;
                    end else if (play_btn) begin
                        w_state_nxt = S_IDLE;
                        w_step_nxt  = '0;
                    end else if (beat_pulse) begin
                        // STEPS is a power of two, so the counter wraps by itself
                        w_step_nxt = r_step + SW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_latch <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_latch <= w_latch_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < STEPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clear) begin
            for (int i = 0; i < STEPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_step] <= w_wr_data;
        end
    end

    assign note_out      = (r_state == S_PLAY) ? r_mem[r_step] : '0;
    assign step          = r_step;
    assign armed         = (r_state == S_ARMED);
    assign recording     = (r_state == S_RECORD);
    assign playing       = (r_state == S_PLAY);
    assign pattern_valid = r_valid;

endmodule

// File: doc/sequencer_recorder.md
Name: sequencer_recorder

Overview:
- Live step recorder: captures notes played on the keyboard, one per beat, into a STEPS-deep pattern memory, then plays the pattern back as a note code.
- Consumes the same beat_pulse and note-code interface that the sequencer's player path produces.
- Sits beside the sequencer. Its note_out feeds the same downstream note/oscillator path as note_sustain.

Parameters:
STEPS, 16, number of pattern slots; power of two, 2..16.
NOTE_W, 4, width of a note code; code 0 means silence.

Ports:
clk  input  1  system clock (10 kHz)
n_rst  input  1  reset; asynchronous, active-low
beat_pulse  input  1  one-cycle pulse per step, from the tempo clock divider
note_in  input  NOTE_W  live note code from the keyboard encoder; 0 = no key
record_btn  input  1  one-cycle pulse (already synchronised/edge-detected): arm, cancel or abort recording
play_btn  input  1  one-cycle pulse: start/stop playback
clear_btn  input  1  one-cycle pulse: erase the pattern
note_out  output  NOTE_W  playback note code; 0 unless playing
step  output  $clog2(STEPS)  current slot index
armed  output  1  high in ARMED
recording  output  1  high in RECORD
playing  output  1  high in PLAY
pattern_valid  output  1  a complete recording is stored

Behaviour:
- Reset (n_rst=0, async): state IDLE, all slots 0, step 0, capture latch 0, pattern_valid 0. All outputs 0.
- States: IDLE, ARMED, RECORD, PLAY. Each of armed/recording/playing is high only in its own state.
- Button priority in the same cycle: clear_btn > record_btn > play_btn. Lower-priority pulses in that cycle are ignored.
- clear_btn, any state: next cycle state IDLE, all slots 0, pattern_valid 0, step 0.
- IDLE:
  - record_btn -> ARMED.
  - play_btn -> PLAY with step 0, only if pattern_valid=1; otherwise ignored.
- ARMED:
  - Waits for the next beat_pulse, then -> RECORD with step 0 and capture latch cleared.
  - record_btn -> IDLE (cancel).
  - play_btn is ignored.
  - If record_btn and beat_pulse arrive in the same cycle, record_btn wins (-> IDLE).
- RECORD, capture rules:
  - Latch holds the first nonzero note_in seen since the step began. Later different notes in the same step do not overwrite it.
  - On beat_pulse: mem[step] <= latch if latch is nonzero, else note_in sampled that same cycle (may be 0). Then the latch is cleared.
- RECORD, step progression:
  - After writing a slot with step < STEPS-1, step increments.
  - After writing slot STEPS-1: state IDLE, step 0, pattern_valid 1.
- RECORD, other events:
  - record_btn -> IDLE (abort). Slots already written are kept, the current step is not written, pattern_valid is unchanged.
  - play_btn is ignored.
  - note_out stays 0 throughout RECORD.
- PLAY:
  - note_out = mem[step], combinational from the slot registers. It changes in the same cycle step updates.
  - On beat_pulse: step increments, wrapping from STEPS-1 to 0.
  - play_btn -> IDLE, note_out 0, step 0.
  - record_btn -> ARMED, step 0.
- step is 0 in IDLE and ARMED.
- Slot storage: STEPS x NOTE_W flops. Slots are written only in RECORD on beat_pulse, or zeroed by clear/reset.
- A beat_pulse in IDLE has no effect.
- A beat_pulse in the cycle PLAY is entered is ignored; the first advance happens on the next beat_pulse.
- No latency beyond one register stage on state and step; note_out has no extra pipeline stage.

Test Plan:
- Reset, then play_btn with no recording -> stays IDLE, playing=0, note_out=0.
- record_btn; beat_pulse; then note_in=5 during step 0, 0 during step 1, 3 then 7 during step 2, 0 for steps 3..15, one beat_pulse per step -> after the 16th write: state IDLE, pattern_valid=1, mem[0..2]=5,0,3.
- Using the pattern from the previous scenario, play_btn then beat_pulses -> note_out sequence 5,0,3,0,...; after step 15 the next beat_pulse wraps step to 0 and note_out=5.
- Abort record_btn during step 4 of a fresh recording after a valid pattern exists -> IDLE; slots 0..3 hold new values, slots 4..15 hold old values, pattern_valid stays 1.
- clear_btn during PLAY -> next cycle IDLE, note_out=0, pattern_valid=0, and all slots read 0 on a later recording check.
- Assert n_rst mid-RECORD at step 7 -> all outputs 0 immediately (asynchronous), and slots are 0 after release.
